br_resolve_unit: RTL and testbench
==================================

# br_resolve_unit

Parametrised branch resolution and prediction unit for the ID stage. It evaluates seven branch conditions on the register operands and drives the IF-stage PC-source select and the IF flush. It also holds a table of 2-bit saturating counters that predicts the direction of each branch at fetch time, and maintains branch and mispredict statistics counters. It replaces the single-cycle equal/not-equal checker and supports predict-taken fetch.

## Interface
- `WORDLENGTH`, 32: operand width in bits.
- `BHT_DEPTH`, 64: number of predictor entries; must be a power of two, minimum 2.
- `STAT_WIDTH`, 16: width of each statistics counter.
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are `clk` and `reset_n`.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `if_pc`  in  WORDLENGTH  PC of the instruction being fetched.
- `if_pred_taken`  out  1  prediction for `if_pc`; combinational table read.
- `id_valid`  in  1  ID holds a real instruction.
- `id_stall`  in  1  ID is stalled; no resolution this cycle.
- `id_pc`  in  WORDLENGTH  PC of the ID instruction.
- `id_pred_taken`  in  1  prediction carried down from IF with the instruction.
- `BranchOp`  in  3  000 none, 001 EQ, 010 NE, 011 LT (signed), 100 GE (signed), 101 LTU, 110 GEU, 111 JUMP.
- `in1`, `in2`  in  WORDLENGTH  forwarded operands.
- `Branch_taken`  out  2  PC-source select: 00 PC+4, 01 branch target, 10 jump target, 11 recover to `id_pc`+4.
- `Flush`  out  1  flush the IF pipeline register.
- `mispredict`  out  1  conditional branch resolved against its prediction.
- `br_count`  out  STAT_WIDTH  conditional branches resolved.
- `mp_count`  out  STAT_WIDTH  mispredicts.

## Operation
- `resolve = id_valid & ~id_stall`. When `resolve` = 0: `Branch_taken` = 00, `Flush` = 0, `mispredict` = 0, and no state changes.
- Index for IF reads and ID updates: `pc[log2(BHT_DEPTH)+1:2]`.
- Condition `taken` for ops 001–110 is computed on full-width operands. LT/GE use signed comparison; LTU/GEU use unsigned.
- Conditional op with `resolve` = 1:
  - `taken` & ~`id_pred_taken`: `Branch_taken` = 01, `Flush` = 1, `mispredict` = 1.
  - ~`taken` & `id_pred_taken`: `Branch_taken` = 11, `Flush` = 1, `mispredict` = 1.
  - Prediction correct: `Branch_taken` = 00, `Flush` = 0, `mispredict` = 0.
- JUMP: `Branch_taken` = 10, `Flush` = 1, `mispredict` = 0. The predictor and statistics are not touched.
- Op 000: outputs are idle, exactly as for `resolve` = 0.
- Predictor update:
  - On each resolved conditional branch, the indexed counter moves +1 if taken, −1 if not, saturating at 11 and 00.
  - `if_pred_taken` = counter[1].
- Statistics:
  - `br_count` increments on each resolved conditional branch.
  - `mp_count` increments on each mispredict.
  - Both wrap modulo 2^STAT_WIDTH.

## Timing
- `Branch_taken`, `Flush` and `mispredict` are combinational from ID inputs, within the same cycle.
- Counter updates take effect at the next rising `clk`.
- If an IF read and an ID update hit the same index in the same cycle, the IF read returns the old (pre-update) value. There is no bypass.
- A stalled instruction is resolved exactly once, in the first cycle with `id_stall` = 0.
- Reset (asynchronous, any time):
  - Every counter → 01 (weakly not-taken).
  - `br_count` and `mp_count` → 0.
  - Combinational outputs follow their inputs. With `id_valid` = 0 they read 00/0/0, and `if_pred_taken` reads 0.
- Reset asserted mid-update: the update is lost, and reset values win.

## Configuration
- `BR_PREDICT_EN`:
  - Defined: the counter table and update logic are built, as above.
  - Undefined: no table is built. `if_pred_taken` is tied 0, so the design is static not-taken. Every taken conditional branch gives 01, `Flush` = 1, `mispredict` = 1. `mp_count` then counts taken conditional branches. Code 11 is never produced.

## Test plan
- Reset, then drive `if_pc` = 0x40 → `if_pred_taken` = 0, `br_count` = `mp_count` = 0, `Branch_taken` = 00.
- EQ with `in1` = `in2` = 5, `id_pred_taken` = 0, at `id_pc` = 0x40 → `Branch_taken` = 01, `Flush` = 1, `mispredict` = 1. After the edge: `mp_count` = 1, `br_count` = 1, `if_pred_taken` at 0x40 = 1.
- LT signed with `in1` = 0xFFFFFFFF, `in2` = 1 → taken. LTU with the same operands → not taken. With `id_pred_taken` = 1, LTU gives `Branch_taken` = 11, `Flush` = 1.
- Resolve the branch at 0x40 taken four times → the counter saturates at 11. One not-taken resolution → 10, and `if_pred_taken` stays 1.
- JUMP with `id_stall` = 1 for 3 cycles → outputs idle and counters unchanged. On the release cycle: `Branch_taken` = 10, `Flush` = 1, `mispredict` = 0.
- With `BR_PREDICT_EN` undefined: NE with `in1` = 1, `in2` = 2 → `if_pred_taken` = 0, `Branch_taken` = 01, `mispredict` = 1. `mp_count` wraps to 0 after 2^STAT_WIDTH such events.

Source files
------------

// File: rtl/br_resolve_unit.sv
// ============================================================================
// Module      : br_resolve_unit
// Description : ID-stage branch resolution with 2-bit counter direction
//               predictor and branch/mispredict statistics.
//               Optional predictor table enabled by macro BR_PREDICT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_resolve_unit #(
    parameter int WORDLENGTH = 32,
    parameter int BHT_DEPTH  = 64,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WORDLENGTH-1:0] if_pc,
    output logic                  if_pred_taken,
    input  logic                  id_valid,
    input  logic                  id_stall,
    input  logic [WORDLENGTH-1:0] id_pc,
    input  logic                  id_pred_taken,
    input  logic [2:0]            BranchOp,
    input  logic [WORDLENGTH-1:0] in1,
    input  logic [WORDLENGTH-1:0] in2,
    output logic [1:0]            Branch_taken,
    output logic                  Flush,
    output logic                  mispredict,
    output logic [STAT_WIDTH-1:0] br_count,
    output logic [STAT_WIDTH-1:0] mp_count
);

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_EQ   = 3'b001;
    localparam logic [2:0] OP_NE   = 3'b010;
    localparam logic [2:0] OP_LT   = 3'b011;
    localparam logic [2:0] OP_GE   = 3'b100;
    localparam logic [2:0] OP_LTU  = 3'b101;
    localparam logic [2:0] OP_GEU  = 3'b110;
    localparam logic [2:0] OP_JUMP = 3'b111;

    localparam logic [1:0] SEL_PC4   = 2'b00;
    localparam logic [1:0] SEL_BR    = 2'b01;
    localparam logic [1:0] SEL_JMP   = 2'b10;
    localparam logic [1:0] SEL_RECOV = 2'b11;

    localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

    logic w_resolve;
    logic w_is_cond;
    logic w_taken;
    logic w_pred;
    logic w_br_event;

    logic [STAT_WIDTH-1:0] br_count_q, br_count_d;
    logic [STAT_WIDTH-1:0] mp_count_q, mp_count_d;

    assign w_resolve  = id_valid & ~id_stall;
    assign w_is_cond  = (BranchOp != OP_NONE) && (BranchOp != OP_JUMP);
    assign w_br_event = w_resolve & w_is_cond;

    always_comb begin
        w_taken = 1'b0;
        case (BranchOp)
            OP_EQ:   w_taken = (in1 == in2);
            OP_NE:   w_taken = (in1 != in2);
            OP_LT:   w_taken = ($signed(in1) <  $signed(in2));
            OP_GE:   w_taken = ($signed(in1) >= $signed(in2));
            OP_LTU:  w_taken = (in1 <  in2);
            OP_GEU:  w_taken = (in1 >= in2);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        Branch_taken = SEL_PC4;
        Flush        = 1'b0;
        mispredict   = 1'b0;
        if (w_resolve) begin
            if (BranchOp == OP_JUMP) begin
                Branch_taken = SEL_JMP;
                Flush        = 1'b1;
            end else if (w_is_cond) begin
                if (w_taken && !w_pred) begin
                    Branch_taken = SEL_BR;
                    Flush        = 1'b1;
                    mispredict   = 1'b1;
                end else if (!w_taken && w_pred) begin
                    // Fetch ran down the predicted-taken path; return to fall-through.
                    Branch_taken = SEL_RECOV;
                    Flush        = 1'b1;
                    mispredict   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        br_count_d = br_count_q;
        mp_count_d = mp_count_q;
        if (w_br_event) begin
            br_count_d = br_count_q + STAT_ONE;
        end
        if (mispredict) begin
            mp_count_d = mp_count_q + STAT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

    assign br_count = br_count_q;
    assign mp_count = mp_count_q;

`ifdef BR_PREDICT_EN
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_id_idx;
    logic [1:0]       w_ctr_old;
    logic [1:0]       w_ctr_d;
    logic             w_unused;

    assign w_if_idx  = if_pc[IDX_W+1:2];
    assign w_id_idx  = id_pc[IDX_W+1:2];
    assign w_ctr_old = bht_q[w_id_idx];
    assign w_pred    = id_pred_taken;
    assign w_unused  = ^{if_pc, id_pc};

    always_comb begin
        w_ctr_d = w_ctr_old;
        if (w_taken) begin
            if (w_ctr_old != 2'b11) w_ctr_d = w_ctr_old + 2'b01;
        end else begin
            if (w_ctr_old != 2'b00) w_ctr_d = w_ctr_old - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (w_br_event) begin
            bht_q[w_id_idx] <= w_ctr_d;
        end
    end

    // Registered-array read: a same-cycle update is not visible to IF.
    assign if_pred_taken = bht_q[w_if_idx][1];
`else
    logic w_unused;

    // Static not-taken: carried prediction is ignored so 11 can never occur.
    assign w_pred        = 1'b0;
    assign if_pred_taken = 1'b0;
    assign w_unused      = ^{if_pc, id_pc, id_pred_taken};
`endif

endmodule

`default_nettype wire

// File: tb/tb_br_resolve_unit.sv
// ============================================================================
// Module      : tb_br_resolve_unit
// Description : Directed table-driven bench for br_resolve_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_br_resolve_unit;

    localparam int WL = 32;
    localparam int SW = 8;

    logic          clk;
    logic          reset_n;
    logic [WL-1:0] if_pc;
    logic          if_pred_taken;
    logic          id_valid;
    logic          id_stall;
    logic [WL-1:0] id_pc;
    logic          id_pred_taken;
    logic [2:0]    BranchOp;
    logic [WL-1:0] in1;
    logic [WL-1:0] in2;
    logic [1:0]    Branch_taken;
    logic          Flush;
    logic          mispredict;
    logic [SW-1:0] br_count;
    logic [SW-1:0] mp_count;

    int checks;
    int errors;
    int exp_br;
    int exp_mp;

    br_resolve_unit #(
        .WORDLENGTH(WL),
        .BHT_DEPTH (64),
        .STAT_WIDTH(SW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .if_pc        (if_pc),
        .if_pred_taken(if_pred_taken),
        .id_valid     (id_valid),
        .id_stall     (id_stall),
        .id_pc        (id_pc),
        .id_pred_taken(id_pred_taken),
        .BranchOp     (BranchOp),
        .in1          (in1),
        .in2          (in2),
        .Branch_taken (Branch_taken),
        .Flush        (Flush),
        .mispredict   (mispredict),
        .br_count     (br_count),
        .mp_count     (mp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        valid;
        logic        stall;
        logic [1:0]  bt;
        logic        fl;
        logic        mp;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        id_valid      = 1'b0;
        id_stall      = 1'b0;
        BranchOp      = 3'd0;
        in1           = '0;
        in2           = '0;
        id_pred_taken = 1'b0;
    endtask

    task automatic step(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic pred, input logic valid,
                        input logic stall, input logic [31:0] pc, input logic [1:0] ebt,
                        input logic efl, input logic emp);
        @(negedge clk);
        BranchOp      = op;
        in1           = a;
        in2           = b;
        id_pred_taken = pred;
        id_valid      = valid;
        id_stall      = stall;
        id_pc         = pc;
        #1;
        chk({nm, " Branch_taken"}, {30'd0, Branch_taken}, {30'd0, ebt});
        chk({nm, " Flush"}, {31'd0, Flush}, {31'd0, efl});
        chk({nm, " mispredict"}, {31'd0, mispredict}, {31'd0, emp});
        if (valid && !stall && op != 3'd0 && op != 3'd7) exp_br++;
        if (emp) exp_mp++;
        @(posedge clk);
        #1;
        chk({nm, " br_count"}, {24'd0, br_count}, exp_br & 32'hFF);
        chk({nm, " mp_count"}, {24'd0, mp_count}, exp_mp & 32'hFF);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_br = 0;
        exp_mp = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        exp_br  = 0;
        exp_mp  = 0;
        reset_n = 1'b0;
        if_pc   = 32'h40;
        id_pc   = 32'h100;
        idle();

        //            op    a             b             v     s     bt     fl    mp
        vecs[0]  = '{3'd1, 32'd5,        32'd5,        1'b1, 1'b0, 2'b01, 1'b1, 1'b1};
        vecs[1]  = '{3'd1, 32'd5,        32'd6,        1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[2]  = '{3'd2, 32'd1,        32'd2,        1'b1, 1'b0, 2'b01, 1'b1, 1'b1};
        vecs[3]  = '{3'd2, 32'd7,        32'd7,        1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[4]  = '{3'd3, 32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 2'b01, 1'b1, 1'b1};
        vecs[5]  = '{3'd5, 32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[6]  = '{3'd4, 32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[7]  = '{3'd6, 32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 2'b01, 1'b1, 1'b1};
        vecs[8]  = '{3'd4, 32'd3,        32'd3,        1'b1, 1'b0, 2'b01, 1'b1, 1'b1};
        vecs[9]  = '{3'd3, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1};
        vecs[10] = '{3'd5, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[11] = '{3'd7, 32'd0,        32'd9,        1'b1, 1'b0, 2'b10, 1'b1, 1'b0};
        vecs[12] = '{3'd0, 32'd5,        32'd5,        1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[13] = '{3'd1, 32'd5,        32'd5,        1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[14] = '{3'd1, 32'd5,        32'd5,        1'b1, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[15] = '{3'd6, 32'd0,        32'd0,        1'b1, 1'b0, 2'b01, 1'b1, 1'b1};

        #2;
        chk("reset if_pred_taken", {31'd0, if_pred_taken}, 32'd0);
        chk("reset br_count", {24'd0, br_count}, 32'd0);
        chk("reset mp_count", {24'd0, mp_count}, 32'd0);
        chk("reset Branch_taken", {30'd0, Branch_taken}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0,
                 vecs[i].valid, vecs[i].stall, 32'h100, vecs[i].bt, vecs[i].fl, vecs[i].mp);
        end

        // Stalled jump held for three cycles, then released.
        for (int i = 0; i < 3; i++) begin
            step("jump_stall", 3'd7, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h100, 2'b00, 1'b0, 1'b0);
        end
        step("jump_release", 3'd7, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h100, 2'b10, 1'b1, 1'b0);

        // Stalled conditional branch counts exactly once.
        step("eq_stall0", 3'd1, 32'd8, 32'd8, 1'b0, 1'b1, 1'b1, 32'h100, 2'b00, 1'b0, 1'b0);
        step("eq_stall1", 3'd1, 32'd8, 32'd8, 1'b0, 1'b1, 1'b1, 32'h100, 2'b00, 1'b0, 1'b0);
        step("eq_release", 3'd1, 32'd8, 32'd8, 1'b0, 1'b1, 1'b0, 32'h100, 2'b01, 1'b1, 1'b1);
        step("after_release", 3'd1, 32'd8, 32'd8, 1'b0, 1'b0, 1'b0, 32'h100, 2'b00, 1'b0, 1'b0);

`ifndef BR_PREDICT_EN
        step("static_ltu_pred1", 3'd5, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 1'b0, 32'h100,
             2'b00, 1'b0, 1'b0);
        step("static_eq_pred1", 3'd1, 32'd4, 32'd4, 1'b1, 1'b1, 1'b0, 32'h100,
             2'b01, 1'b1, 1'b1);
`endif

        // Asynchronous reset in the middle of an update cycle.
        @(negedge clk);
        BranchOp = 3'd2; in1 = 32'd1; in2 = 32'd2; id_valid = 1'b1; id_stall = 1'b0;
        id_pred_taken = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset br_count", {24'd0, br_count}, 32'd0);
        chk("async_reset mp_count", {24'd0, mp_count}, 32'd0);
        chk("reset comb Branch_taken", {30'd0, Branch_taken}, 32'd1);
        @(posedge clk);
        #1;
        chk("held_reset mp_count", {24'd0, mp_count}, 32'd0);
        chk("held_reset if_pred_taken", {31'd0, if_pred_taken}, 32'd0);
        @(negedge clk);
        idle();
        reset_n = 1'b1;
        exp_br = 0;
        exp_mp = 0;

`ifdef BR_PREDICT_EN
        do_reset();
        if_pc = 32'h40;
        #1;
        chk("bht reset pred", {31'd0, if_pred_taken}, 32'd0);
        step("bht_eq_first", 3'd1, 32'd5, 32'd5, 1'b0, 1'b1, 1'b0, 32'h40, 2'b01, 1'b1, 1'b1);
        chk("bht pred after first", {31'd0, if_pred_taken}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step("bht_sat", 3'd1, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 32'h40, 2'b00, 1'b0, 1'b0);
        end
        step("bht_nt1", 3'd1, 32'd5, 32'd6, 1'b1, 1'b1, 1'b0, 32'h40, 2'b11, 1'b1, 1'b1);
        chk("bht pred after one nt", {31'd0, if_pred_taken}, 32'd1);
        step("bht_nt2", 3'd1, 32'd5, 32'd6, 1'b1, 1'b1, 1'b0, 32'h40, 2'b11, 1'b1, 1'b1);
        chk("bht pred after two nt", {31'd0, if_pred_taken}, 32'd0);
        step("bht_ltu_pred1", 3'd5, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 1'b0, 32'h80,
             2'b11, 1'b1, 1'b1);
        if_pc = 32'hC0;
        @(negedge clk);
        BranchOp = 3'd1; in1 = 32'd3; in2 = 32'd3; id_pred_taken = 1'b0;
        id_valid = 1'b1; id_stall = 1'b0; id_pc = 32'hC0;
        #1;
        chk("no_bypass same cycle", {31'd0, if_pred_taken}, 32'd0);
        exp_br++;
        exp_mp++;
        @(posedge clk);
        #1;
        chk("no_bypass next cycle", {31'd0, if_pred_taken}, 32'd1);
        chk("no_bypass br_count", {24'd0, br_count}, exp_br & 32'hFF);
        @(negedge clk);
        idle();
`endif

        // Statistics wrap after 2^STAT_WIDTH mispredicting branches.
        do_reset();
        if_pc = 32'h200;
        for (int i = 0; i < (1 << SW); i++) begin
            step("wrap", 3'd2, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0, 32'h100, 2'b01, 1'b1, 1'b1);
`ifndef BR_PREDICT_EN
            chk("wrap if_pred_taken", {31'd0, if_pred_taken}, 32'd0);
`endif
            if (i == (1 << SW) - 2) begin
                chk("wrap mp_count max", {24'd0, mp_count}, 32'hFF);
            end
        end
        chk("wrap mp_count zero", {24'd0, mp_count}, 32'd0);
        chk("wrap br_count zero", {24'd0, br_count}, 32'd0);

        @(negedge clk);
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
